// File: rtl/ocl_fifo_readout.sv
// AXI-Lite slave exposing NUM_CH independent 32-bit FIFOs with status, sticky errors and an ID word.
// Optional macro OCL_FIFO_PEEK_EN: CTRL-offset reads return the FIFO head without popping.
module ocl_fifo_readout #(
    parameter int          NUM_CH   = 4,
    parameter int          DEPTH    = 16,
    parameter logic [31:0] ID_VALUE = 32'hF1F0_0000
) (
    input  logic        clk_main_a0,
    input  logic        rst_main,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    output logic        awready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        wready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    input  logic        bready,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    output logic        arready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    input  logic        rready,
    output logic [15:0] vled_q
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [31:0] ID_WORD     = ID_VALUE | (32'(NUM_CH) << 8) | 32'(AW);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [AW:0] PTR_ONE     = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [31:0] mem [NUM_CH][DEPTH];
    logic [AW:0] wr_ptr [NUM_CH];
    logic [AW:0] rd_ptr [NUM_CH];
    logic [AW:0] count [NUM_CH];
    logic [31:0] head [NUM_CH];
    logic [31:0] status [NUM_CH];

    logic [NUM_CH-1:0] ovf_flag, udf_flag, full, empty;
    logic [NUM_CH-1:0] push_en, pop_en, flush_en, ovf_set, udf_set;

    logic [11:0] w_addr;
    logic        w_fire, r_fire;
    logic [1:0]  bresp_nxt, rresp_nxt;
    logic [31:0] rdata_nxt;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{awaddr[31:12], araddr[31:12]};
    assign w_fire = (w_state == W_DATA) && wvalid;
    assign r_fire = (r_state == R_IDLE) && arvalid;

    always_comb begin
        full  = '0;
        empty = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            count[c]  = wr_ptr[c] - rd_ptr[c];
            empty[c]  = (wr_ptr[c] == rd_ptr[c]);
            full[c]   = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                        (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
            head[c]   = mem[c][rd_ptr[c][AW-1:0]];
            status[c] = {12'd0, udf_flag[c], ovf_flag[c], full[c], empty[c], 16'(count[c])};
        end
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                wready = wvalid;
                if (wvalid) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Full/empty come from the pre-cycle pointers, so a same-cycle push and pop never see each other.
    always_comb begin
        bresp_nxt = RESP_OKAY;
        push_en   = '0;
        flush_en  = '0;
        ovf_set   = '0;
        if (w_fire) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_addr[11:4] == 8'(c)) begin
                    if (w_addr[3:0] == 4'h0) begin
                        if (wstrb != 4'hF) begin
                            bresp_nxt = RESP_SLVERR;
                        end else if (full[c]) begin
                            bresp_nxt  = RESP_SLVERR;
                            ovf_set[c] = 1'b1;
                        end else begin
                            push_en[c] = 1'b1;
                        end
                    end else if (w_addr[3:0] == 4'h8 && wdata[0]) begin
                        flush_en[c] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rdata_nxt = 32'hDEAD_BEEF;
        rresp_nxt = RESP_OKAY;
        pop_en    = '0;
        udf_set   = '0;
        if (araddr[11:0] == 12'h100) rdata_nxt = ID_WORD;
        for (int c = 0; c < NUM_CH; c++) begin
            if (araddr[11:4] == 8'(c)) begin
                case (araddr[3:0])
                    4'h0: begin
                        if (empty[c]) begin
                            rdata_nxt  = '0;
                            rresp_nxt  = RESP_SLVERR;
                            udf_set[c] = r_fire;
                        end else begin
                            rdata_nxt = head[c];
                            pop_en[c] = r_fire;
                        end
                    end
                    4'h4: rdata_nxt = status[c];
`ifdef OCL_FIFO_PEEK_EN
                    4'h8: begin
                        if (empty[c]) begin
                            rdata_nxt = '0;
                            rresp_nxt = RESP_SLVERR;
                        end else begin
                            rdata_nxt = head[c];
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            w_addr <= '0;
            bresp  <= RESP_OKAY;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
            vled_q <= '0;
        end else begin
            if (w_state == W_IDLE && awvalid) w_addr <= awaddr[11:0];
            if (w_fire) bresp <= bresp_nxt;
            if (push_en[0]) vled_q <= wdata[15:0];
            if (r_fire) begin
                rdata <= rdata_nxt;
                rresp <= rresp_nxt;
            end
        end
    end

    // A flush wins over any sticky-flag set or pop landing in the same cycle.
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            ovf_flag <= '0;
            udf_flag <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (flush_en[c]) begin
                    wr_ptr[c]   <= '0;
                    rd_ptr[c]   <= '0;
                    ovf_flag[c] <= 1'b0;
                    udf_flag[c] <= 1'b0;
                end else begin
                    if (push_en[c]) wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
                    if (pop_en[c])  rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
                    if (ovf_set[c]) ovf_flag[c] <= 1'b1;
                    if (udf_set[c]) udf_flag[c] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_main_a0) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push_en[c]) mem[c][wr_ptr[c][AW-1:0]] <= wdata;
        end
    end

endmodule

// File: tb/tb_ocl_fifo_readout.sv
// Randomised self-checking bench for ocl_fifo_readout against a queue-based model of the register map.
module tb_ocl_fifo_readout;

    localparam int          NUM_CH   = 4;
    localparam int          DEPTH    = 16;
    localparam logic [31:0] ID_VALUE = 32'hF1F0_0000;
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  SLVERR   = 2'b10;

    logic        clk_main_a0, rst_main;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [15:0] vled_q;

    int tests = 0;
    int fails = 0;

    ocl_fifo_readout #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ID_VALUE(ID_VALUE)) dut (
        .clk_main_a0(clk_main_a0), .rst_main(rst_main),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .vled_q(vled_q)
    );

    initial clk_main_a0 = 1'b0;
    always #5 clk_main_a0 = ~clk_main_a0;

    typedef struct packed {logic [1:0] resp; logic [15:0] vled;} b_exp_t;
    typedef struct packed {logic [31:0] data; logic [1:0] resp;} r_exp_t;

    b_exp_t      exp_b[$];
    r_exp_t      exp_r[$];
    logic [31:0] mq [NUM_CH][$];
    bit          m_ovf [NUM_CH];
    bit          m_udf [NUM_CH];
    logic [15:0] m_vled = '0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int ch;
        ch = int'(addr[11:4]);
        if (ch >= NUM_CH) return OKAY;
        if (addr[3:0] == 4'h0) begin
            if (strb != 4'hF) return SLVERR;
            if (mq[ch].size() == DEPTH) begin
                m_ovf[ch] = 1'b1;
                return SLVERR;
            end
            mq[ch].push_back(data);
            if (ch == 0) m_vled = data[15:0];
        end else if (addr[3:0] == 4'h8 && data[0]) begin
            mq[ch].delete();
            m_ovf[ch] = 1'b0;
            m_udf[ch] = 1'b0;
        end
        return OKAY;
    endfunction

    function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                       output logic [1:0] resp);
        int ch;
        int n;
        data = 32'hDEAD_BEEF;
        resp = OKAY;
        ch   = int'(addr[11:4]);
        if (addr[11:0] == 12'h100) begin
            data = ID_VALUE | 32'(NUM_CH * 256) | 32'($clog2(DEPTH));
            return;
        end
        if (ch >= NUM_CH) return;
        n = mq[ch].size();
        case (addr[3:0])
            4'h0: begin
                if (n == 0) begin
                    data = '0;
                    resp = SLVERR;
                    m_udf[ch] = 1'b1;
                end else begin
                    data = mq[ch].pop_front();
                end
            end
            4'h4: data = {12'd0, m_udf[ch], m_ovf[ch], n == DEPTH, n == 0, 16'(n)};
`ifdef OCL_FIFO_PEEK_EN
            4'h8: begin
                if (n == 0) begin
                    data = '0;
                    resp = SLVERR;
                end else begin
                    data = mq[ch][0];
                end
            end
`endif
            default: ;
        endcase
    endfunction

    // Every cycle a response is presented it must match the model's head entry and stay stable until accepted.
    always @(negedge clk_main_a0) begin
        if (!rst_main) begin
            if (bvalid) begin
                if (exp_b.size() == 0) begin
                    check_output("unexpected_bvalid", 32'(bvalid), 32'd0);
                end else begin
                    check_output("bresp", 32'(bresp), 32'(exp_b[0].resp));
                    check_output("vled_q", 32'(vled_q), 32'(exp_b[0].vled));
                    check_output("awready_during_resp", 32'(awready), 32'd0);
                    if (bready) void'(exp_b.pop_front());
                end
            end
            if (rvalid) begin
                if (exp_r.size() == 0) begin
                    check_output("unexpected_rvalid", 32'(rvalid), 32'd0);
                end else begin
                    check_output("rdata", rdata, exp_r[0].data);
                    check_output("rresp", 32'(rresp), 32'(exp_r[0].resp));
                    check_output("arready_during_read", 32'(arready), 32'd0);
                    if (rready) void'(exp_r.pop_front());
                end
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int bdelay, output logic [1:0] er);
        b_exp_t e;
        int     n;
        e.resp = model_write(addr, data, strb);
        e.vled = m_vled;
        er     = e.resp;
        exp_b.push_back(e);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        do begin @(negedge clk_main_a0); n++; end while (!awready && n < 50);
        if (!awready) check_output("awready_timeout", 32'(awready), 32'd1);
        @(posedge clk_main_a0); #1 awvalid = 1'b0;
        n = 0;
        do begin @(negedge clk_main_a0); n++; end while (!wready && n < 50);
        if (!wready) check_output("wready_timeout", 32'(wready), 32'd1);
        @(posedge clk_main_a0); #1 wvalid = 1'b0;
        if (bdelay == 0) bready = 1'b1;
        @(negedge clk_main_a0);
        check_output("bvalid_latency", 32'(bvalid), 32'd1);
        if (bdelay > 0) begin
            repeat (bdelay) @(posedge clk_main_a0);
            #1 bready = 1'b1;
            @(negedge clk_main_a0);
        end
        @(posedge clk_main_a0); #1 bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rdelay,
                            output logic [31:0] ed, output logic [1:0] er);
        r_exp_t e;
        int     n;
        model_read(addr, e.data, e.resp);
        ed = e.data;
        er = e.resp;
        exp_r.push_back(e);
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        do begin @(negedge clk_main_a0); n++; end while (!arready && n < 50);
        if (!arready) check_output("arready_timeout", 32'(arready), 32'd1);
        @(posedge clk_main_a0); #1 arvalid = 1'b0;
        if (rdelay == 0) rready = 1'b1;
        @(negedge clk_main_a0);
        check_output("rvalid_latency", 32'(rvalid), 32'd1);
        if (rdelay > 0) begin
            repeat (rdelay) @(posedge clk_main_a0);
            #1 rready = 1'b1;
            @(negedge clk_main_a0);
        end
        @(posedge clk_main_a0); #1 rready = 1'b0;
    endtask

    // Write beat and read handshake land on the same edge; both are judged against the pre-cycle FIFO.
    task automatic apply_stimulus(input int ch, input logic [31:0] woff, input logic [31:0] data,
                                  input logic [31:0] roff, output logic [31:0] ed,
                                  output logic [1:0] er, output logic [1:0] ebr);
        b_exp_t be;
        r_exp_t re;
        bit     pre_full;
        logic [31:0] base;
        base     = 32'(ch * 16);
        pre_full = (woff == 32'h0) && (mq[ch].size() == DEPTH);
        model_read(base + roff, re.data, re.resp);
        if (pre_full) begin
            m_ovf[ch] = 1'b1;
            be.resp   = SLVERR;
        end else begin
            be.resp = model_write(base + woff, data, 4'hF);
        end
        be.vled = m_vled;
        ed = re.data; er = re.resp; ebr = be.resp;
        exp_r.push_back(re);
        exp_b.push_back(be);
        @(posedge clk_main_a0);
        #1 awaddr = base + woff; awvalid = 1'b1;
        wdata = data; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b1; rready = 1'b1;
        @(posedge clk_main_a0);
        #1 awvalid = 1'b0; araddr = base + roff; arvalid = 1'b1;
        @(posedge clk_main_a0);
        #1 wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk_main_a0);
        #1 bready = 1'b0; rready = 1'b0;
        check_output("simul_drain", 32'(exp_b.size() + exp_r.size()), 32'd0);
    endtask

    task automatic check_reset_values();
        check_output("rst_awready", 32'(awready), 32'd1);
        check_output("rst_arready", 32'(arready), 32'd1);
        check_output("rst_wready", 32'(wready), 32'd0);
        check_output("rst_bvalid", 32'(bvalid), 32'd0);
        check_output("rst_rvalid", 32'(rvalid), 32'd0);
        check_output("rst_bresp", 32'(bresp), 32'd0);
        check_output("rst_rresp", 32'(rresp), 32'd0);
        check_output("rst_rdata", rdata, 32'd0);
        check_output("rst_vled_q", 32'(vled_q), 32'd0);
    endtask

    task automatic random_ops(input int count);
        int          ch, dly, pick;
        logic [31:0] base, addr, ed;
        logic [3:0]  strb;
        logic [1:0]  er, ebr;
        for (int i = 0; i < count; i++) begin
            ch   = int'($urandom_range(NUM_CH - 1));
            base = 32'(ch * 16);
            dly  = int'($urandom_range(2));
            case ($urandom_range(9))
                0, 1, 2: begin
                    strb = ($urandom_range(7) == 0) ? 4'($urandom) : 4'hF;
                    axi_write(base, $urandom, strb, dly, er);
                end
                3, 4: axi_read(base, dly, ed, er);
                5:    axi_read(base + 32'h4, dly, ed, er);
                6:    axi_write(base + 32'h8, {31'($urandom), ($urandom_range(5) == 0)}, 4'hF, dly, er);
                7: begin
                    pick = int'($urandom_range(3));
                    addr = (pick == 0) ? 32'h100 : (pick == 1) ? base + 32'hC :
                           (pick == 2) ? base + 32'h8 : 32'h300;
                    axi_read(addr, dly, ed, er);
                end
                8:       apply_stimulus(ch, 32'h0, $urandom, 32'h0, ed, er, ebr);
                default: axi_write(32'h200, $urandom, 4'hF, dly, er);
            endcase
        end
    endtask

    initial begin
        logic [31:0] ed;
        logic [1:0]  er, ebr;

        rst_main = 1'b1;
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; rready = 1'b0;
        repeat (3) @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        check_reset_values();
        @(posedge clk_main_a0); #1 rst_main = 1'b0;

        axi_read(32'h100, 0, ed, er);
        check_output("id_word", ed, 32'hF1F0_0404);

        for (int k = 1; k <= 3; k++) axi_write(32'h10, 32'h1111_0000 + 32'(k), 4'hF, 0, er);
        for (int k = 1; k <= 3; k++) begin
            axi_read(32'h10, k - 1, ed, er);
            check_output("ch1_pop_order", ed, 32'h1111_0000 + 32'(k));
        end
        axi_read(32'h14, 0, ed, er);
        check_output("ch1_status_empty", ed, 32'h0001_0000);

        for (int k = 1; k <= DEPTH + 1; k++) axi_write(32'h0, 32'(k), 4'hF, 0, er);
        check_output("ch0_overflow_bresp", 32'(er), 32'(SLVERR));
        axi_read(32'h4, 0, ed, er);
        check_output("ch0_status_full", ed, 32'h0006_0010);
        check_output("ch0_vled_after_overflow", 32'(vled_q), 32'h0010);

        axi_read(32'h20, 0, ed, er);
        check_output("ch2_underflow_data", ed, 32'h0);
        check_output("ch2_underflow_resp", 32'(er), 32'(SLVERR));
        axi_read(32'h24, 0, ed, er);
        check_output("ch2_status_udf", ed, 32'h0009_0000);
        axi_write(32'h28, 32'h1, 4'hF, 1, er);
        axi_read(32'h24, 0, ed, er);
        check_output("ch2_status_flushed", ed, 32'h0001_0000);

        axi_write(32'h10, 32'hCAFE_0001, 4'h3, 0, er);
        check_output("partial_strobe_bresp", 32'(er), 32'(SLVERR));
        axi_read(32'h14, 0, ed, er);
        check_output("partial_strobe_status", ed, 32'h0001_0000);

        axi_write(32'h30, 32'h0000_0055, 4'hF, 0, er);
        axi_read(32'h30, 5, ed, er);
        check_output("held_pop_data", ed, 32'h55);

`ifdef OCL_FIFO_PEEK_EN
        axi_write(32'h30, 32'h0000_ABCD, 4'hF, 0, er);
        for (int k = 0; k < 2; k++) begin
            axi_read(32'h38, 0, ed, er);
            check_output("peek_data", ed, 32'hABCD);
        end
        axi_read(32'h34, 0, ed, er);
        check_output("peek_status", ed, 32'h0000_0001);
        axi_read(32'h30, 0, ed, er);
`else
        axi_read(32'h38, 0, ed, er);
        check_output("ctrl_read_deadbeef", ed, 32'hDEAD_BEEF);
`endif
        axi_read(32'h0C, 0, ed, er);
        check_output("unmapped_read", ed, 32'hDEAD_BEEF);
        axi_write(32'h200, 32'h1234, 4'hF, 0, er);
        check_output("unmapped_write_bresp", 32'(er), 32'(OKAY));

        apply_stimulus(1, 32'h0, 32'h77, 32'h0, ed, er, ebr);
        check_output("simul_empty_pop_resp", 32'(er), 32'(SLVERR));
        check_output("simul_empty_push_resp", 32'(ebr), 32'(OKAY));
        axi_read(32'h14, 0, ed, er);
        check_output("simul_empty_status", ed, 32'h0008_0001);
        apply_stimulus(0, 32'h0, 32'h99, 32'h0, ed, er, ebr);
        check_output("simul_full_pop_data", ed, 32'h1);
        check_output("simul_full_push_resp", 32'(ebr), 32'(SLVERR));
        axi_read(32'h4, 0, ed, er);
        check_output("simul_full_status", ed, 32'h0004_000F);
        apply_stimulus(1, 32'h0, 32'h88, 32'h0, ed, er, ebr);
        check_output("simul_mid_pop_data", ed, 32'h77);
        apply_stimulus(1, 32'h8, 32'h1, 32'h0, ed, er, ebr);
        check_output("flush_pop_data", ed, 32'h88);
        axi_read(32'h14, 0, ed, er);
        check_output("flush_pop_status", ed, 32'h0001_0000);

        random_ops(300);

        axi_write(32'h8, 32'h1, 4'hF, 0, er);
        axi_write(32'h0, 32'h0000_5A5A, 4'hF, 0, er);
        check_output("vled_before_reset", 32'(vled_q), 32'h5A5A);
        @(posedge clk_main_a0);
        #1 awaddr = 32'h0; awvalid = 1'b1; wvalid = 1'b0;
        @(posedge clk_main_a0);
        #1 awvalid = 1'b0;
        @(negedge clk_main_a0);
        check_output("in_wdata_awready", 32'(awready), 32'd0);
        @(posedge clk_main_a0);
        #1 rst_main = 1'b1;
        exp_b.delete();
        exp_r.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            mq[c].delete();
            m_ovf[c] = 1'b0;
            m_udf[c] = 1'b0;
        end
        m_vled = '0;
        @(negedge clk_main_a0);
        check_reset_values();
        @(posedge clk_main_a0); #1 rst_main = 1'b0;
        axi_read(32'h4, 0, ed, er);
        check_output("post_reset_ch0_status", ed, 32'h0001_0000);

        random_ops(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
